// File: rtl/xy_write_arbiter_if.sv
// Write-port bundle shared by the sequencing controller, the host loader and the XY memory.
// The master side drives requests and sees grants; the slave side is the arbiter.
interface xy_write_arbiter_if #(
    parameter int XY_MEM_DEPTH = 10,
    parameter int DATA_WIDTH   = 16
);
    logic                    ctrl_req;
    logic [XY_MEM_DEPTH-1:0] ctrl_addr;
    logic [DATA_WIDTH-1:0]   ctrl_data;
    logic                    ctrl_lock;
    logic                    ctrl_grant;
    logic                    host_valid;
    logic [XY_MEM_DEPTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0]   host_data;
    logic                    host_last;
    logic                    host_ready;
    logic [XY_MEM_DEPTH-1:0] xy_write_addr;
    logic [DATA_WIDTH-1:0]   xy_write_data;
    logic                    xy_write_enable;
    logic                    host_starved;

    modport master (
        output ctrl_req, ctrl_addr, ctrl_data, ctrl_lock,
        output host_valid, host_addr, host_data, host_last,
        input  ctrl_grant, host_ready,
        input  xy_write_addr, xy_write_data, xy_write_enable, host_starved
    );

    modport slave (
        input  ctrl_req, ctrl_addr, ctrl_data, ctrl_lock,
        input  host_valid, host_addr, host_data, host_last,
        output ctrl_grant, host_ready,
        output xy_write_addr, xy_write_data, xy_write_enable, host_starved
    );
endinterface

// File: rtl/xy_write_arbiter.sv
// Arbitrates the single XY-memory write port between the controller (priority) and the host
// loader, with bounded host bursts, a starvation escape for the host and a controller lock.
module xy_write_arbiter #(
    parameter int XY_MEM_DEPTH = 10,
    parameter int DATA_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int BURST_MAX    = 8
) (
    input  logic             clk,
    input  logic             reset,
    xy_write_arbiter_if.slave bus
);
    localparam int BEAT_W   = $clog2(BURST_MAX + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_FULL = STARVE_W'(STARVE_LIMIT);
    localparam logic [BEAT_W-1:0]   BEAT_LAST   = BEAT_W'(BURST_MAX);

    typedef enum logic [0:0] {S_CTRL = 1'b0, S_HOST = 1'b1} state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [STARVE_W-1:0]     starve_cnt_r;
    logic [STARVE_W-1:0]     starve_nxt_s;
    logic [BEAT_W-1:0]       beat_cnt_r;
    logic [BEAT_W-1:0]       beat_nxt_s;
    logic                    host_take_s;
    logic                    ctrl_grant_s;
    logic                    host_ready_s;
    logic [XY_MEM_DEPTH-1:0] wr_addr_s;
    logic [DATA_WIDTH-1:0]   wr_data_s;
    logic [XY_MEM_DEPTH-1:0] xy_write_addr_r;
    logic [DATA_WIDTH-1:0]   xy_write_data_r;
    logic                    xy_write_enable_r;
    logic                    host_starved_r;

    // Next-state, counter and handshake decode for both ownership states.
    always_comb begin
        state_nxt_s  = state_r;
        starve_nxt_s = starve_cnt_r;
        beat_nxt_s   = beat_cnt_r;
        host_take_s  = 1'b0;
        ctrl_grant_s = 1'b0;
        host_ready_s = 1'b0;
        case (state_r)
            S_CTRL: begin
                host_take_s  = bus.host_valid && !bus.ctrl_lock &&
                               (!bus.ctrl_req || (starve_cnt_r == STARVE_FULL));
                host_ready_s = host_take_s;
                ctrl_grant_s = bus.ctrl_req && !host_take_s;
                if (host_take_s) begin
                    starve_nxt_s = {STARVE_W{1'b0}};
                    if (!bus.host_last && (BURST_MAX > 1)) begin
                        state_nxt_s = S_HOST;
                        beat_nxt_s  = BEAT_W'(1);
                    end else begin
                        state_nxt_s = S_CTRL;
                        beat_nxt_s  = {BEAT_W{1'b0}};
                    end
                end else if (bus.host_valid && !bus.ctrl_lock) begin
                    // Host lost this cycle to the controller; saturate rather than wrap.
                    starve_nxt_s = (starve_cnt_r == STARVE_FULL) ? STARVE_FULL
                                                                 : starve_cnt_r + STARVE_W'(1);
                end else begin
                    starve_nxt_s = {STARVE_W{1'b0}};
                end
            end
            S_HOST: begin
                host_ready_s = bus.host_valid && !bus.ctrl_lock;
                if (host_ready_s && !bus.host_last && (beat_cnt_r + BEAT_W'(1) != BEAT_LAST)) begin
                    beat_nxt_s = beat_cnt_r + BEAT_W'(1);
                end else begin
                    // Burst finished, capped, idle or locked out: hand the port back.
                    state_nxt_s  = S_CTRL;
                    beat_nxt_s   = {BEAT_W{1'b0}};
                    starve_nxt_s = {STARVE_W{1'b0}};
                end
            end
            default: begin
                state_nxt_s  = S_CTRL;
                beat_nxt_s   = {BEAT_W{1'b0}};
                starve_nxt_s = {STARVE_W{1'b0}};
            end
        endcase
    end

    // Select the beat that wins the port this cycle.
    always_comb begin
        wr_addr_s = bus.ctrl_addr;
        wr_data_s = bus.ctrl_data;
        if (host_ready_s) begin
            wr_addr_s = bus.host_addr;
            wr_data_s = bus.host_data;
        end else begin
            wr_addr_s = bus.ctrl_addr;
            wr_data_s = bus.ctrl_data;
        end
    end

    // State, counters and the registered memory write port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r           <= S_CTRL;
            starve_cnt_r      <= {STARVE_W{1'b0}};
            beat_cnt_r        <= {BEAT_W{1'b0}};
            xy_write_addr_r   <= {XY_MEM_DEPTH{1'b0}};
            xy_write_data_r   <= {DATA_WIDTH{1'b0}};
            xy_write_enable_r <= 1'b0;
            host_starved_r    <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            starve_cnt_r   <= starve_nxt_s;
            beat_cnt_r     <= beat_nxt_s;
            host_starved_r <= (starve_nxt_s == STARVE_FULL);
            if (ctrl_grant_s || host_ready_s) begin
                xy_write_addr_r   <= wr_addr_s;
                xy_write_data_r   <= wr_data_s;
                xy_write_enable_r <= 1'b1;
            end else begin
                xy_write_enable_r <= 1'b0;
            end
        end
    end

    // Handshakes are combinational but held off for the whole reset window.
    assign bus.ctrl_grant      = ctrl_grant_s && reset;
    assign bus.host_ready      = host_ready_s && reset;
    assign bus.xy_write_addr   = xy_write_addr_r;
    assign bus.xy_write_data   = xy_write_data_r;
    assign bus.xy_write_enable = xy_write_enable_r;
    assign bus.host_starved    = host_starved_r;
endmodule

// File: tb/tb_xy_write_arbiter.sv
// Directed scenarios followed by a long randomized run, all checked against a behavioural
// model of the arbitration rules (burst ownership, lost-cycle count, one-cycle write latency).
module tb_xy_write_arbiter;
    localparam int AW           = 10;
    localparam int DW           = 16;
    localparam int STARVE_LIMIT = 4;
    localparam int BURST_MAX    = 8;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   seq    = 0;

    // Reference model state
    bit            m_in_burst = 1'b0;
    int            m_beats    = 0;
    int            m_lost     = 0;
    logic          e_en;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_starved;
    logic          last_cg;
    logic          last_hr;

    xy_write_arbiter_if #(.XY_MEM_DEPTH(AW), .DATA_WIDTH(DW)) bus ();

    xy_write_arbiter #(
        .XY_MEM_DEPTH(AW), .DATA_WIDTH(DW),
        .STARVE_LIMIT(STARVE_LIMIT), .BURST_MAX(BURST_MAX)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check the handshakes, advance the model, check the port.
    task automatic step(input logic r, input logic cr, input logic cl, input logic hv,
                        input logic hl, input logic [AW-1:0] ca, input logic [AW-1:0] ha,
                        input logic [DW-1:0] cd, input logic [DW-1:0] hd);
        logic m_cg;
        logic m_hr;
        int   nxt;
        @(negedge clk);
        reset          = r;
        bus.ctrl_req   = cr;
        bus.ctrl_lock  = cl;
        bus.ctrl_addr  = ca;
        bus.ctrl_data  = cd;
        bus.host_valid = hv;
        bus.host_last  = hl;
        bus.host_addr  = ha;
        bus.host_data  = hd;
        #1;
        if (!r) begin
            m_cg = 1'b0;
            m_hr = 1'b0;
        end else if (m_in_burst) begin
            m_cg = 1'b0;
            m_hr = hv && !cl;
        end else begin
            m_hr = hv && !cl && (!cr || m_lost >= STARVE_LIMIT);
            m_cg = cr && !m_hr;
        end
        chk("ctrl_grant", {31'd0, bus.ctrl_grant}, {31'd0, m_cg});
        chk("host_ready", {31'd0, bus.host_ready}, {31'd0, m_hr});
        chk("exclusive", {31'd0, bus.ctrl_grant && bus.host_ready}, 32'd0);
        last_cg = bus.ctrl_grant;
        last_hr = bus.host_ready;
        @(posedge clk);
        if (!r) begin
            m_in_burst = 1'b0;
            m_beats    = 0;
            m_lost     = 0;
            e_en       = 1'b0;
            e_addr     = '0;
            e_data     = '0;
        end else begin
            e_en = m_cg || m_hr;
            if (m_hr) begin
                e_addr     = ha;
                e_data     = hd;
                m_beats    = m_in_burst ? m_beats + 1 : 1;
                m_in_burst = !(hl || m_beats >= BURST_MAX);
                if (!m_in_burst) m_beats = 0;
                m_lost = 0;
            end else begin
                if (m_cg) begin
                    e_addr = ca;
                    e_data = cd;
                end
                if (m_in_burst) begin
                    m_in_burst = 1'b0;
                    m_beats    = 0;
                    m_lost     = 0;
                end else if (hv && !cl) begin
                    nxt    = m_lost + 1;
                    m_lost = (nxt > STARVE_LIMIT) ? STARVE_LIMIT : nxt;
                end else begin
                    m_lost = 0;
                end
            end
        end
        e_starved = (m_lost == STARVE_LIMIT);
        #1;
        chk("xy_write_enable", {31'd0, bus.xy_write_enable}, {31'd0, e_en});
        chk("xy_write_addr", {22'd0, bus.xy_write_addr}, {22'd0, e_addr});
        chk("xy_write_data", {16'd0, bus.xy_write_data}, {16'd0, e_data});
        chk("host_starved", {31'd0, bus.host_starved}, {31'd0, e_starved});
    endtask

    // Out-of-reset cycle with a fresh, distinct address/data pair on each side.
    task automatic go(input logic cr, input logic cl, input logic hv, input logic hl);
        seq++;
        step(1'b1, cr, cl, hv, hl, AW'(seq), AW'(seq + 512),
             DW'(32'hC000 + seq), DW'(32'h4000 + seq));
    endtask

    initial begin
        int g;
        int h;
        // Reset with both sides requesting
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h3FF, 10'h155, 16'hFFFF, 16'h5555);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h3FF, 10'h155, 16'hFFFF, 16'h5555);
        // Release: controller granted the same cycle, written one cycle later
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h012, 10'h000, 16'hABCD, 16'h0000);
        chk("release_grant", {31'd0, last_cg}, 32'd1);
        go(1'b0, 1'b0, 1'b0, 1'b0);

        // Starvation: four controller wins, then the host is forced a beat
        g = 0;
        for (int i = 0; i < 5; i++) begin
            go(1'b1, 1'b0, 1'b1, 1'b1);
            if (i < 4) g += int'(last_cg);
            if (i == 3) chk("starved_flag", {31'd0, bus.host_starved}, 32'd1);
            if (i == 4) chk("starve_host_beat", {31'd0, last_hr}, 32'd1);
        end
        chk("starve_ctrl_grants", 32'(g), 32'd4);
        go(1'b0, 1'b0, 1'b0, 1'b0);

        // Burst cap with controller idle: 12 beats flow back to back
        h = 0;
        for (int i = 0; i < 12; i++) begin
            go(1'b0, 1'b0, 1'b1, 1'b0);
            h += int'(last_hr);
        end
        chk("cap_idle_beats", 32'(h), 32'd12);
        go(1'b0, 1'b0, 1'b0, 1'b0);

        // Burst cap with controller waiting: it wins right after the eighth beat
        go(1'b0, 1'b0, 1'b1, 1'b0);
        h = 0;
        for (int i = 0; i < 7; i++) begin
            go(1'b1, 1'b0, 1'b1, 1'b0);
            h += int'(last_hr);
        end
        chk("cap_burst_beats", 32'(h), 32'd7);
        go(1'b1, 1'b0, 1'b1, 1'b0);
        chk("cap_ctrl_after", {31'd0, last_cg}, 32'd1);
        go(1'b0, 1'b0, 1'b0, 1'b0);

        // Burst end on host_last with controller pending
        go(1'b0, 1'b0, 1'b1, 1'b0);
        go(1'b1, 1'b0, 1'b1, 1'b0);
        go(1'b1, 1'b0, 1'b1, 1'b1);
        chk("end_beat3", {31'd0, last_hr}, 32'd1);
        go(1'b1, 1'b0, 1'b1, 1'b0);
        chk("end_ctrl_next", {31'd0, last_cg}, 32'd1);
        go(1'b0, 1'b0, 1'b0, 1'b0);

        // Lock arriving after beat 2 of a burst
        go(1'b0, 1'b0, 1'b1, 1'b0);
        go(1'b0, 1'b0, 1'b1, 1'b0);
        go(1'b0, 1'b1, 1'b1, 1'b0);
        chk("lock_blocks", {31'd0, last_hr}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            go(1'b1, 1'b1, 1'b1, 1'b0);
            chk("lock_no_starve", {31'd0, bus.host_starved}, 32'd0);
        end
        go(1'b0, 1'b0, 1'b1, 1'b1);
        chk("unlock_host", {31'd0, last_hr}, 32'd1);

        // Reset in the middle of a burst discards it
        go(1'b0, 1'b0, 1'b1, 1'b0);
        go(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h001, 10'h002, 16'h0003, 16'h0004);
        chk("reset_no_write", {31'd0, bus.xy_write_enable}, 32'd0);

        // Randomized traffic, occasional resets
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 63) != 0,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) == 0,
                 AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
